// File: rtl/agc_gain_writer_pkg.sv
// Shared types and constants for the AGC gain writer: FSM state encoding,
// default settings-bus address for SR_GAIN and the power datapath width.
package agc_gain_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CMP  = 2'd2,
        ST_WR   = 2'd3
    } agc_state_e;

    localparam int unsigned SR_GAIN_ADDR_DEF = 192;
    localparam int unsigned PWR_WIDTH        = 32;

endpackage

// File: rtl/agc_gain_writer_power_window.sv
// Windowed mean-power measurement: registered I^2+Q^2, window counter and
// accumulator producing avg_pwr plus a one-cycle avg_done per window.
module agc_power_window
    import agc_gain_writer_pkg::*;
#(
    parameter int SAMP_WIDTH = 16,
    parameter int LOG_WIN    = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    s_valid,
    input  logic [2*SAMP_WIDTH-1:0] s_data,
    output logic [PWR_WIDTH-1:0]    avg_pwr,
    output logic                    avg_done
);

    localparam int ACC_W = PWR_WIDTH + LOG_WIN;

    logic signed [SAMP_WIDTH-1:0]   samp_i;
    logic signed [SAMP_WIDTH-1:0]   samp_q;
    logic signed [2*SAMP_WIDTH-1:0] prod_i;
    logic signed [2*SAMP_WIDTH-1:0] prod_q;

    logic [PWR_WIDTH-1:0] sq_d, sq_q;
    logic                 sq_valid_d, sq_valid_q;
    logic                 sq_last_d, sq_last_q;
    logic [LOG_WIN-1:0]   cnt_d, cnt_q;

    logic [ACC_W-1:0]     acc_d, acc_q;
    logic [ACC_W-1:0]     acc_sum;
    logic [PWR_WIDTH-1:0] avg_pwr_d, avg_pwr_q;
    logic                 avg_done_d, avg_done_q;

    assign samp_i = s_data[2*SAMP_WIDTH-1:SAMP_WIDTH];
    assign samp_q = s_data[SAMP_WIDTH-1:0];
    assign prod_i = samp_i * samp_i;
    assign prod_q = samp_q * samp_q;

    // Squares are never negative, so the signed products can be added unsigned;
    // the worst case (-2^15)^2 * 2 = 2^31 still fits.
    always_comb begin
        sq_d       = PWR_WIDTH'($unsigned(prod_i)) + PWR_WIDTH'($unsigned(prod_q));
        sq_valid_d = s_valid && !clear;
        sq_last_d  = s_valid && (cnt_q == '1);
        cnt_d      = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (s_valid) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign acc_sum = acc_q + ACC_W'(sq_q);

    always_comb begin
        acc_d      = acc_q;
        avg_pwr_d  = avg_pwr_q;
        avg_done_d = 1'b0;
        if (clear) begin
            acc_d = '0;
        end else if (sq_valid_q) begin
            if (sq_last_q) begin
                avg_pwr_d  = PWR_WIDTH'(acc_sum >> LOG_WIN);
                acc_d      = '0;
                avg_done_d = 1'b1;
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sq_q       <= '0;
            sq_valid_q <= 1'b0;
            sq_last_q  <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            avg_pwr_q  <= '0;
            avg_done_q <= 1'b0;
        end else begin
            sq_q       <= sq_d;
            sq_valid_q <= sq_valid_d;
            sq_last_q  <= sq_last_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            avg_pwr_q  <= avg_pwr_d;
            avg_done_q <= avg_done_d;
        end
    end

    assign avg_pwr  = avg_pwr_q;
    assign avg_done = avg_done_q;

endmodule

// File: rtl/agc_gain_writer.sv
// Closed-loop AGC: measures windowed sample power, steps the gain toward a
// target with a dead band, and writes each new gain over the settings bus.
//
//   state | meaning
//   IDLE  | loop disabled; window cleared, gain held
//   RUN   | waiting for the end of a power window
//   CMP   | compare power against target, compute new gain
//   WR    | settings strobe carrying the current gain
module agc_gain_writer
    import agc_gain_writer_pkg::*;
#(
    parameter int                    SAMP_WIDTH   = 16,
    parameter int                    LOG_WIN      = 10,
    parameter int                    SR_GAIN_ADDR = SR_GAIN_ADDR_DEF,
    parameter int                    GAIN_WIDTH   = 16,
    parameter logic [GAIN_WIDTH-1:0] GAIN_INIT    = 16'h4000,
    parameter int                    STEP_SHIFT   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2*SAMP_WIDTH-1:0] i_tdata,
    input  logic                    i_tvalid,
    output logic                    i_tready,
    input  logic                    enable,
    input  logic [31:0]             target_pwr,
    input  logic [31:0]             hyst,
    output logic                    set_stb,
    output logic [7:0]              set_addr,
    output logic [31:0]             set_data,
    output logic [GAIN_WIDTH-1:0]   gain,
    output logic [31:0]             avg_pwr
);

    localparam logic [7:0] ADDR8 = 8'(SR_GAIN_ADDR);

    agc_state_e state_d, state_q;

    logic [GAIN_WIDTH-1:0] gain_d, gain_q;
    logic                  set_stb_d, set_stb_q;
    logic [7:0]            set_addr_d, set_addr_q;
    logic [31:0]           set_data_d, set_data_q;

    logic                  avg_done;
    logic [PWR_WIDTH-1:0]  avg_pwr_w;

    logic [GAIN_WIDTH-1:0] step_raw;
    logic [GAIN_WIDTH-1:0] step;
    logic [GAIN_WIDTH-1:0] gain_dec;
    logic [GAIN_WIDTH:0]   gain_inc_full;
    logic [GAIN_WIDTH-1:0] gain_inc;
    logic [PWR_WIDTH:0]    hi_thr;
    logic [PWR_WIDTH:0]    pwr_plus_hyst;
    logic                  pwr_hi;
    logic                  pwr_lo;
    logic [GAIN_WIDTH-1:0] gain_cmp;

    assign i_tready = 1'b1;

    agc_power_window #(
        .SAMP_WIDTH (SAMP_WIDTH),
        .LOG_WIN    (LOG_WIN)
    ) u_power_window (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (!enable),
        .s_valid  (i_tvalid && enable),
        .s_data   (i_tdata),
        .avg_pwr  (avg_pwr_w),
        .avg_done (avg_done)
    );

    // Thresholds are formed one bit wider so target+hyst cannot wrap.
    always_comb begin
        step_raw      = gain_q >> STEP_SHIFT;
        step          = (step_raw == '0) ? GAIN_WIDTH'(1) : step_raw;
        gain_dec      = (gain_q > step) ? (gain_q - step) : GAIN_WIDTH'(1);
        gain_inc_full = {1'b0, gain_q} + {1'b0, step};
        gain_inc      = gain_inc_full[GAIN_WIDTH] ? '1 : gain_inc_full[GAIN_WIDTH-1:0];
        hi_thr        = {1'b0, target_pwr} + {1'b0, hyst};
        pwr_plus_hyst = {1'b0, avg_pwr_w} + {1'b0, hyst};
        pwr_hi        = {1'b0, avg_pwr_w} > hi_thr;
        pwr_lo        = pwr_plus_hyst < {1'b0, target_pwr};
        if (pwr_hi) begin
            gain_cmp = gain_dec;
        end else if (pwr_lo) begin
            gain_cmp = gain_inc;
        end else begin
            gain_cmp = gain_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        gain_d     = gain_q;
        set_stb_d  = 1'b0;
        set_addr_d = set_addr_q;
        set_data_d = set_data_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_WR;
                    set_stb_d  = 1'b1;
                    set_addr_d = ADDR8;
                    set_data_d = 32'(gain_q);
                end
                ST_RUN: begin
                    if (avg_done) begin
                        state_d = ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (gain_cmp != gain_q) begin
                        gain_d     = gain_cmp;
                        state_d    = ST_WR;
                        set_stb_d  = 1'b1;
                        set_addr_d = ADDR8;
                        set_data_d = 32'(gain_cmp);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_WR: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            gain_q     <= GAIN_INIT;
            set_stb_q  <= 1'b0;
            set_addr_q <= '0;
            set_data_q <= '0;
        end else begin
            state_q    <= state_d;
            gain_q     <= gain_d;
            set_stb_q  <= set_stb_d;
            set_addr_q <= set_addr_d;
            set_data_q <= set_data_d;
        end
    end

    // A drop of enable during the write cycle suppresses the strobe at once.
    assign set_stb  = set_stb_q && enable;
    assign set_addr = set_addr_q;
    assign set_data = set_data_q;
    assign gain     = gain_q;
    assign avg_pwr  = avg_pwr_w;

endmodule

// File: tb/tb_agc_gain_writer.sv
// Self-checking bench for agc_gain_writer: event-timeline reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_agc_gain_writer;

    localparam int LW  = 2;
    localparam int WIN = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] i_tdata = '0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic        enable = 1'b0;
    logic [31:0] target_pwr = '0;
    logic [31:0] hyst = '0;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [15:0] gain;
    logic [31:0] avg_pwr;

    int n_chk = 0;
    int n_err = 0;

    agc_gain_writer #(
        .SAMP_WIDTH   (16),
        .LOG_WIN      (LW),
        .SR_GAIN_ADDR (192),
        .GAIN_WIDTH   (16),
        .GAIN_INIT    (16'h4000),
        .STEP_SHIFT   (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_tdata    (i_tdata),
        .i_tvalid   (i_tvalid),
        .i_tready   (i_tready),
        .enable     (enable),
        .target_pwr (target_pwr),
        .hyst       (hyst),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .gain       (gain),
        .avg_pwr    (avg_pwr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: power per window, then fixed latencies to the
    // decision and the strobe, cancelled by enable going low.
    logic        m_stb = 1'b0;
    logic [15:0] m_gain = 16'h4000;
    logic [31:0] m_avg = '0;
    logic [31:0] m_data = '0;
    logic [7:0]  m_addr = '0;
    longint      m_acc = 0;
    longint      m_avg_val = 0;
    int          m_cnt = 0;
    int          m_cyc = 0;
    int          avg_due = -1;
    int          dec_due = -1;
    bit          running = 1'b0;

    function automatic longint pwr(input logic [31:0] d);
        longint a;
        longint b;
        a = longint'($signed(d[31:16]));
        b = longint'($signed(d[15:0]));
        return a * a + b * b;
    endfunction

    task automatic model_reset();
        m_stb = 1'b0; m_gain = 16'h4000; m_avg = '0; m_data = '0; m_addr = '0;
        m_acc = 0; m_cnt = 0; avg_due = -1; dec_due = -1; running = 1'b0;
    endtask

    task automatic model_decide();
        longint a, t, h;
        int g, s, ng;
        a = longint'(m_avg); t = longint'(target_pwr); h = longint'(hyst);
        g = int'(m_gain);
        s = g / 16;
        if (s < 1) s = 1;
        ng = g;
        if (a > t + h) begin
            ng = g - s;
            if (ng < 1) ng = 1;
        end else if (a + h < t) begin
            ng = g + s;
            if (ng > 65535) ng = 65535;
        end
        if (ng != g) begin
            m_gain = 16'(ng);
            m_stb  = 1'b1;
            m_addr = 8'd192;
            m_data = 32'(ng);
        end
    endtask

    task automatic model_step();
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_stb = 1'b0;
        if (!enable) begin
            running = 1'b0; m_acc = 0; m_cnt = 0; avg_due = -1; dec_due = -1;
        end else begin
            if (!running) begin
                running = 1'b1; m_stb = 1'b1; m_addr = 8'd192; m_data = 32'(m_gain);
            end
            if (dec_due == m_cyc + 1) begin
                model_decide();
                dec_due = -1;
            end
            if (avg_due == m_cyc + 1) begin
                m_avg   = 32'(m_avg_val);
                dec_due = m_cyc + 3;
                avg_due = -1;
            end
            if (i_tvalid) begin
                m_acc += pwr(i_tdata);
                m_cnt++;
                if (m_cnt == WIN) begin
                    avg_due   = m_cyc + 2;
                    m_avg_val = m_acc >> LW;
                    m_acc     = 0;
                    m_cnt     = 0;
                end
            end
        end
        m_cyc++;
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("tready",   i_tready, 1'b1);
        chk("set_stb",  set_stb,  m_stb & enable);
        chk("set_addr", set_addr, m_addr);
        chk("set_data", set_data, m_data);
        chk("gain",     gain,     m_gain);
        chk("avg_pwr",  avg_pwr,  m_avg);
    end

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_iq(input logic [15:0] iv, input logic [15:0] qv);
        i_tdata = {iv, qv};
    endtask

    task automatic wait_strobe(input int max_cyc, input logic [31:0] exp_data,
                               input bit tog, input string name);
        bit got = 1'b0;
        for (int k = 0; k < max_cyc && !got; k++) begin
            step1();
            if (tog) i_tvalid = ~i_tvalid;
            @(negedge clk);
            if (set_stb) got = 1'b1;
        end
        chk({name, " seen"}, got, 1'b1);
        if (got) begin
            chk(name, set_data, exp_data);
            chk({name, " addr"}, set_addr, 8'd192);
        end
    endtask

    task automatic count_strobes(input int ncyc, output int cnt);
        cnt = 0;
        for (int k = 0; k < ncyc; k++) begin
            step1();
            @(negedge clk);
            if (set_stb) cnt++;
        end
    endtask

    task automatic reset_pulse();
        step1();
        reset_n = 1'b0; enable = 1'b0; i_tvalid = 1'b0;
        step1();
        step1();
        reset_n = 1'b1;
        step1();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        bit got;
        target_pwr = 32'h0100_0000;
        hyst       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst gain",    gain,     16'h4000);
        chk("rst set_stb", set_stb,  1'b0);
        chk("rst avg",     avg_pwr,  32'h0);
        chk("rst data",    set_data, 32'h0);
        step1();
        reset_n = 1'b1;
        step1();

        // Enable rise: immediate write of the reset gain.
        enable = 1'b1;
        wait_strobe(5, 32'h0000_4000, 1'b0, "en strobe");
        chk("en gain", gain, 16'h4000);

        // High power: 0x4000 -> 0x3C00 -> 0x3840.
        step1();
        set_iq(16'h1000, 16'h1000);
        i_tvalid = 1'b1;
        wait_strobe(20, 32'h0000_3C00, 1'b0, "dec1");
        chk("dec1 avg", avg_pwr, 32'h0200_0000);
        wait_strobe(10, 32'h0000_3840, 1'b0, "dec2");

        // Low power with toggling valid: 0x4000 -> 0x4400 -> 0x4840 -> 0x4CC4.
        reset_pulse();
        set_iq(16'h0100, 16'h0100);
        target_pwr = 32'h0100_0000;
        hyst       = '0;
        enable     = 1'b1;
        i_tvalid   = 1'b1;
        wait_strobe(5, 32'h0000_4000, 1'b1, "lo en");
        wait_strobe(40, 32'h0000_4400, 1'b1, "inc1");
        chk("inc1 avg", avg_pwr, 32'h0002_0000);
        wait_strobe(40, 32'h0000_4840, 1'b1, "inc2");
        chk("inc2 avg", avg_pwr, 32'h0002_0000);
        step1();
        i_tvalid = 1'b1;
        wait_strobe(20, 32'h0000_4CC4, 1'b0, "inc3");
        chk("inc3 avg", avg_pwr, 32'h0002_0000);

        // Dead band: no writes over more than 10 windows.
        reset_pulse();
        set_iq(16'h1000, 16'h1000);
        target_pwr = 32'h0200_0000;
        hyst       = 32'h0000_0100;
        enable     = 1'b1;
        i_tvalid   = 1'b1;
        wait_strobe(5, 32'h0000_4000, 1'b0, "db en");
        count_strobes(50, n);
        chk("db strobes", 64'(n), 64'd0);
        chk("db gain", gain, 16'h4000);
        chk("db avg", avg_pwr, 32'h0200_0000);

        // Upper saturation.
        target_pwr = 32'hFFFF_FFFF;
        hyst       = '0;
        count_strobes(400, n);
        chk("sat hi gain", gain, 16'hFFFF);
        count_strobes(40, n);
        chk("sat hi strobes", 64'(n), 64'd0);

        // Lower saturation.
        target_pwr = '0;
        count_strobes(2000, n);
        chk("sat lo gain", gain, 16'h0001);
        count_strobes(40, n);
        chk("sat lo strobes", 64'(n), 64'd0);

        // Mid-window enable drop, then re-enable on new samples only.
        target_pwr = 32'h0100_0000;
        step1();
        step1();
        enable = 1'b0;
        step1();
        step1();
        set_iq(16'h0800, 16'h0800);
        step1();
        enable = 1'b1;
        wait_strobe(5, 32'h0000_0001, 1'b0, "reen");
        wait_strobe(20, 32'h0000_0002, 1'b0, "reen inc");
        chk("reen avg", avg_pwr, 32'h0080_0000);

        // Reset asserted during a write cycle drops the strobe immediately.
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step1();
            @(negedge clk);
            if (set_stb) got = 1'b1;
        end
        chk("wr seen", got, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async stb", set_stb, 1'b0);
        chk("async gain", gain, 16'h4000);
        chk("async data", set_data, 32'h0);
        step1();
        step1();
        reset_n = 1'b1;
        enable  = 1'b0;
        step1();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/agc_gain_writer.md
Name: agc_gain_writer

Overview:
- Closed-loop companion to the RFNoC gain block. Taps the complex sample stream, measures mean power over fixed windows, and steps a gain value toward a programmed target.
- Acts as the settings-bus initiator: it writes each new gain to the gain block's SR_GAIN register with set_stb/set_addr/set_data.
- Sits in the ce_clk domain, beside the noc_shell settings bus.

Parameters:
- SAMP_WIDTH, 16: signed width of each I and Q component.
- LOG_WIN, 10: window length is 2^LOG_WIN accepted samples. Legal range 2..16.
- SR_GAIN_ADDR, 192: settings address driven on set_addr.
- GAIN_WIDTH, 16: unsigned gain width.
- GAIN_INIT, 16'h4000: gain value after reset.
- STEP_SHIFT, 4: gain step is gain >> STEP_SHIFT, with a minimum step of 1.

Ports:
- clk  in  1  compute-engine clock.
- reset_n  in  1  asynchronous active-low reset.
- i_tdata  in  2*SAMP_WIDTH  sample; I is in the upper half, Q in the lower half, both signed.
- i_tvalid  in  1  sample valid.
- i_tready  out  1  constant 1; the block is a passive tap.
- enable  in  1  loop enable.
- target_pwr  in  32  target mean power, unsigned.
- hyst  in  32  dead-band half-width, unsigned.
- set_stb  out  1  settings write strobe, one-cycle pulse.
- set_addr  out  8  settings address.
- set_data  out  32  settings data, equal to {zero pad, gain}.
- gain  out  GAIN_WIDTH  current gain.
- avg_pwr  out  32  most recent window mean power.

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset values: set_stb=0, set_addr=0, set_data=0, gain=GAIN_INIT, avg_pwr=0, accumulator=0, sample counter=0, state=IDLE.
- A sample is accepted when i_tvalid=1 and enable=1. i_tready stays 1 at all times, including during reset.
- Stage 1 (registered): sq = I*I + Q*Q as 32-bit unsigned; the maximum value 2^31 fits. sq carries a last flag, set when the sample counter equals 2^LOG_WIN-1. The counter wraps to 0 on that sample.
- Stage 2, accumulator of width 32+LOG_WIN:
  - sq valid and last clear: acc <= acc + sq.
  - sq valid and last set: avg_pwr <= (acc + sq) >> LOG_WIN (truncating), acc <= 0, and avg_done pulses for one cycle.
  - Windows are back to back. No sample is dropped or double-counted at a window boundary.
- FSM states:
  - IDLE: entered from any state when enable=0. Clears acc and the counter and discards pipeline contents; gain holds. On enable 0->1, go to WR with the current gain.
  - RUN: waits for avg_done, then goes to CMP.
  - CMP: one cycle.
    - If avg_pwr > target_pwr + hyst (33-bit compare), gain_next = max(gain - step, 1).
    - Else if avg_pwr + hyst < target_pwr (33-bit compare), gain_next = min(gain + step, 2^GAIN_WIDTH - 1).
    - Else gain_next = gain.
    - Here step = max(gain >> STEP_SHIFT, 1).
    - If gain_next != gain, update gain and go to WR; otherwise go to RUN.
  - WR: set_stb=1 for exactly one cycle, with set_addr=SR_GAIN_ADDR and set_data=gain. Then go to RUN.
- Settings output: set_addr and set_data are registered and hold between strobes.
- Timing: the last sample of a window accepted in cycle N gives avg_done in N+2, CMP in N+3 and set_stb in N+4.
- Overlap: the minimum window of 4 samples guarantees that CMP/WR complete before the next avg_done.
- Mid-operation changes:
  - target_pwr and hyst are sampled only in CMP.
  - enable falling in CMP or WR aborts; no strobe is issued.
  - reset_n asserted mid-operation immediately restores all reset values, including dropping set_stb.

Decomposition:
- Shared package: the FSM state encoding (IDLE, RUN, CMP, WR), the default SR_GAIN address constant 192, and the power width constant 32.
- One natural sub-module, agc_power_window: squarer, window counter and accumulator, outputting avg_pwr and avg_done. The FSM, gain arithmetic and settings interface stay in the top module.

Test Plan:
- Reset, then enable 0->1: one set_stb with addr=192, data=0x00004000; gain=0x4000.
- LOG_WIN=2, I=Q=0x1000 continuous, target=0x01000000, hyst=0: avg_pwr=0x02000000; set_stb 4 cycles after the 4th sample, with data 0x3C00, then 0x3840 on the next window.
- I=Q=0x0100, target=0x01000000, hyst=0: gain 0x4000 -> 0x4400 -> 0x4840. Windows of i_tvalid toggling 1/0 give an identical avg_pwr.
- Dead band: avg_pwr=0x02000000, target=0x02000000, hyst=0x100: no set_stb over 10 windows; gain unchanged.
- Saturation: gain=1 with high power -> gain stays 1, no strobe. Gain 0xF800 with low power -> 0xFFFF, one strobe, then none.
- Mid-window enable drop, then re-enable: one strobe with the current gain. The next avg_pwr covers only post-enable samples. Asserting reset_n mid-WR clears set_stb asynchronously.
